// File: rtl/lcd_cmd_sequencer.sv
// HD44780 command/character sequencer: power-up wait, 4-bit init, then each byte -> 4 PCF8574 frames.
// Latency: first frame one cycle after accept; frames back-to-back while i2c_ready is high.
// Backpressure: frames hold while i2c_ready=0; cmd_ready is high only in IDLE, with no queueing.
module lcd_cmd_sequencer #(
    parameter int POWERUP_CYC = 2000000,
    parameter int SHORT_CYC   = 2500,
    parameter int LONG_CYC    = 100000,
    parameter bit BACKLIGHT   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_rs,
    output logic       i2c_valid,
    input  logic       i2c_ready,
    output logic [7:0] i2c_byte,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_A = (POWERUP_CYC > LONG_CYC) ? POWERUP_CYC : LONG_CYC;
    localparam int MAX_C = (MAX_A > SHORT_CYC) ? MAX_A : SHORT_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYC - 1);

    typedef enum logic [2:0] {
        PWRUP     = 3'd0,
        INIT_LOAD = 3'd1,
        SEND      = 3'd2,
        DELAY     = 3'd3,
        IDLE      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [2:0]    init_k;
    logic [7:0]    lat_data;
    logic          lat_rs;

    // Fixed 4-bit-mode init program; 0x33/0x32 force the controller into 4-bit mode.
    function automatic logic [7:0] rom_entry(input logic [2:0] k);
        case (k)
            3'd0:    return 8'h33;
            3'd1:    return 8'h32;
            3'd2:    return 8'h28;
            3'd3:    return 8'h0C;
            3'd4:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Expander frame: high nibble first, EN high on even frames and low on odd frames, RW always 0.
    function automatic logic [7:0] frame(input logic [7:0] d, input logic rs, input logic [1:0] i);
        logic [3:0] nib;
        nib = i[1] ? d[3:0] : d[7:4];
        return {nib, BACKLIGHT, ~i[0], 1'b0, rs};
    endfunction

    // Clear, home and the two mode-forcing init bytes need the long execution time.
    function automatic logic is_long(input logic [7:0] d, input logic rs);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h33 || d == 8'h32);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= PWRUP;
        else        state <= state_nx;
    end

    // Next-state decode and state-decoded handshake/status outputs.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        i2c_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            PWRUP:     if (cnt == PWR_LAST) state_nx = INIT_LOAD;
            INIT_LOAD: state_nx = SEND;
            SEND: begin
                i2c_valid = 1'b1;
                if (i2c_ready && idx == 2'd3) state_nx = DELAY;
            end
            DELAY: begin
                if (cnt == '0) begin
                    if (init_done || init_k == 3'd5) state_nx = IDLE;
                    else                             state_nx = INIT_LOAD;
                end
            end
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nx = SEND;
            end
            default: state_nx = PWRUP;
        endcase
    end

    // Datapath: wait/delay counter, frame index, init pointer, command latch and registered output byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            init_k    <= 3'd0;
            init_done <= 1'b0;
            lat_data  <= 8'h00;
            lat_rs    <= 1'b0;
            i2c_byte  <= 8'h00;
        end else begin
            case (state)
                PWRUP: begin
                    if (cnt == PWR_LAST) cnt <= '0;
                    else                 cnt <= cnt + CW'(1);
                end
                INIT_LOAD: begin
                    lat_data <= rom_entry(init_k);
                    lat_rs   <= 1'b0;
                    idx      <= 2'd0;
                    i2c_byte <= frame(rom_entry(init_k), 1'b0, 2'd0);
                end
                IDLE: begin
                    if (cmd_valid) begin
                        lat_data <= cmd_data;
                        lat_rs   <= cmd_rs;
                        idx      <= 2'd0;
                        i2c_byte <= frame(cmd_data, cmd_rs, 2'd0);
                    end
                end
                SEND: begin
                    if (i2c_ready) begin
                        if (idx == 2'd3) begin
                            cnt <= is_long(lat_data, lat_rs) ? LONG_LAST : SHORT_LAST;
                        end else begin
                            idx      <= idx + 2'd1;
                            i2c_byte <= frame(lat_data, lat_rs, idx + 2'd1);
                        end
                    end
                end
                DELAY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!init_done) begin
                        if (init_k == 3'd5) init_done <= 1'b1;
                        else                init_k    <= init_k + 3'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: scoreboard of expected expander bytes plus a command vector table.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
// Covers init stream, command frames, short/long delays, stall hold, ignored commands, reset mid-send.
module tb_lcd_cmd_sequencer;

    localparam int P_PWR   = 10;
    localparam int P_SHORT = 4;
    localparam int P_LONG  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_rs = 1'b0;
    logic       i2c_valid;
    logic       i2c_ready = 1'b1;
    logic [7:0] i2c_byte;
    logic       init_done;
    logic       busy;

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .POWERUP_CYC(P_PWR),
        .SHORT_CYC  (P_SHORT),
        .LONG_CYC   (P_LONG),
        .BACKLIGHT  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_rs   (cmd_rs),
        .i2c_valid(i2c_valid),
        .i2c_ready(i2c_ready),
        .i2c_byte (i2c_byte),
        .init_done(init_done),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0]  data;
        logic        rs;
        logic [31:0] bytes;
        int          dly;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] init_bytes [6];
    logic [7:0]  exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          n_pop    = 0;
    int          rdy_bad  = 0;
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_byte = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [31:0] b);
        for (int i = 0; i < 4; i++) exp_q.push_back(b[31-8*i -: 8]);
    endtask

    // Pops one expected byte per handshake and checks that stalled frames hold.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (stall_prev && reset)
                check("stall_hold", 32'({i2c_valid, i2c_byte}), 32'({1'b1, stall_byte}));
            stall_prev = reset && i2c_valid && !i2c_ready;
            stall_byte = i2c_byte;
            if (i2c_valid && i2c_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(i2c_byte), 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(i2c_byte), 32'(e));
                    n_pop++;
                end
            end
        end
    endtask

    task automatic wait_empty(input string nm, input int budget, input bit chk_rdy);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            sample();
            if (chk_rdy && cmd_ready) rdy_bad++;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    // Counts idle-line cycles after the last frame until ready (or init_done); optionally pokes cmd_valid.
    task automatic measure_gap(input string nm, input int exp_d, input bit use_done, input bit pulse);
        int g;
        bit hit;
        g   = 0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            sample();
            if (use_done ? init_done : cmd_ready) begin
                hit = 1'b1;
                break;
            end
            if (use_done && cmd_ready) rdy_bad++;
            cmd_data  = 8'h55;
            cmd_rs    = 1'b0;
            cmd_valid = pulse && (g < exp_d - 1);
            g++;
        end
        cmd_valid = 1'b0;
        check(nm, hit ? 32'(g) : 32'hFFFF_FFFF, 32'(exp_d));
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic rs, input logic [31:0] b, input bit stall);
        drive_edge();
        cmd_data  = d;
        cmd_rs    = rs;
        cmd_valid = 1'b1;
        push4(b);
        sample();
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        drive_edge();
        cmd_valid = 1'b0;
        sample();
        check("send_state", 32'({busy, cmd_ready, i2c_valid}), 32'b101);
        if (stall) begin
            drive_edge();
            drive_edge();
            i2c_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
                sample();
                check("stall_idx2", 32'({i2c_valid, i2c_byte}), 32'({1'b1, b[15:8]}));
                drive_edge();
            end
            i2c_ready = 1'b1;
        end
        wait_empty("cmd_drain", 50, 1'b0);
    endtask

    // Releases reset and follows the whole power-up wait and init program.
    task automatic do_init(input bit pulse);
        int  base;
        int  lowc;
        bit  seen;
        for (int i = 0; i < 6; i++) push4(init_bytes[i]);
        base    = n_pop;
        rdy_bad = 0;
        drive_edge();
        reset = 1'b1;
        if (pulse) begin
            cmd_data  = 8'h55;
            cmd_rs    = 1'b0;
            cmd_valid = 1'b1;
        end
        lowc = 0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            sample();
            if (i2c_valid) begin
                seen = 1'b1;
                break;
            end
            lowc++;
            if (cmd_ready) rdy_bad++;
        end
        // Power-up cycles plus the single INIT_LOAD cycle before the first frame appears.
        check("pwrup_wait", seen ? 32'(lowc) : 32'hFFFF_FFFF, 32'(P_PWR + 1));
        repeat (3) sample();
        check("first_four_consecutive", 32'(n_pop - base), 32'd4);
        cmd_valid = 1'b0;
        wait_empty("init_drain", 400, 1'b1);
        measure_gap("init_long_delay", P_LONG, 1'b1, pulse);
        check("init_byte_count", 32'(n_pop - base), 32'd24);
        check("init_cmd_ready_low", 32'(rdy_bad), 32'd0);
        check("idle_after_init", 32'({busy, cmd_ready}), 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        init_bytes[0] = 32'h3C383C38;
        init_bytes[1] = 32'h3C382C28;
        init_bytes[2] = 32'h2C288C88;
        init_bytes[3] = 32'h0C08CCC8;
        init_bytes[4] = 32'h0C086C68;
        init_bytes[5] = 32'h0C081C18;

        tbl[0] = '{data: 8'h41, rs: 1'b1, bytes: 32'h4D491D19, dly: P_SHORT};
        tbl[1] = '{data: 8'h01, rs: 1'b0, bytes: 32'h0C081C18, dly: P_LONG};
        tbl[2] = '{data: 8'h02, rs: 1'b0, bytes: 32'h0C082C28, dly: P_LONG};
        tbl[3] = '{data: 8'h33, rs: 1'b1, bytes: 32'h3D393D39, dly: P_SHORT};
        tbl[4] = '{data: 8'h32, rs: 1'b0, bytes: 32'h3C382C28, dly: P_LONG};
        tbl[5] = '{data: 8'hA5, rs: 1'b1, bytes: 32'hADA95D59, dly: P_SHORT};
        tbl[6] = '{data: 8'h80, rs: 1'b0, bytes: 32'h8C880C08, dly: P_SHORT};

        fork
            monitor();
        join_none

        #2 reset = 1'b0;
        repeat (3) drive_edge();
        sample();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_i2c_valid", 32'(i2c_valid), 32'd0);
        check("rst_i2c_byte", 32'(i2c_byte), 32'h00);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        do_init(1'b1);

        for (int i = 0; i < 7; i++) begin
            send_cmd(tbl[i].data, tbl[i].rs, tbl[i].bytes, 1'b0);
            measure_gap("cmd_delay", tbl[i].dly, 1'b0, i == 0);
            check("idle_not_busy", 32'(busy), 32'd0);
        end

        // A command poked during the previous DELAY must not start a transfer.
        repeat (3) begin
            sample();
            check("no_spurious_send", 32'(i2c_valid), 32'd0);
        end

        send_cmd(8'h41, 1'b1, 32'h4D491D19, 1'b1);
        measure_gap("stall_cmd_delay", P_SHORT, 1'b0, 1'b0);

        // Reset while frame idx 1 is on the bus.
        drive_edge();
        cmd_data  = 8'h02;
        cmd_rs    = 1'b0;
        cmd_valid = 1'b1;
        push4(32'h0C082C28);
        drive_edge();
        cmd_valid = 1'b0;
        drive_edge();
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(i2c_valid), 32'd0);
        check("rst_mid_byte", 32'(i2c_byte), 32'h00);
        check("rst_mid_state", 32'({busy, cmd_ready, init_done}), 32'b100);
        check("rst_mid_popped", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        repeat (2) drive_edge();
        do_init(1'b0);

        send_cmd(8'h41, 1'b1, 32'h4D491D19, 1'b0);
        measure_gap("post_reset_delay", P_SHORT, 1'b0, 1'b0);
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
